// File: rtl/vga_pkg.sv
// Shared VGA/game definitions: overlay select code, frame rate and a counter width helper.
package vga_pkg;

  typedef enum logic [1:0] {
    GA_MENU = 2'd0,
    GA_PLAY = 2'd1,
    GA_END  = 2'd2
  } game_active_t;

  localparam int unsigned FRAMES_PER_SEC = 60;

  // At least one bit, so counters for parameters of 1 remain legal.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the vsync level into a registered one-cycle tick on each rising edge.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vsync,
  output logic tick
);

  logic vsync_q;
  logic tick_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= vsync;
      tick_q  <= vsync & ~vsync_q;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow sequencer: menu, world init, play timer, post-outcome freeze and end screen.
// Optional PAUSE_EN macro adds a pause_toggle input and a paused state.
module game_state_ctrl #(
  parameter int unsigned FRAMES_PER_SEC = vga_pkg::FRAMES_PER_SEC,
  parameter int unsigned FREEZE_FRAMES  = 90,
  parameter int unsigned INIT_CYCLES    = 4,
  parameter int unsigned MAX_SECONDS    = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vsync,
  input  logic       game_start,
  input  logic [1:0] char_class,
  input  logic       player_dead,
  input  logic       boss_dead,
`ifdef PAUSE_EN
  input  logic       pause_toggle,
`endif
  output logic [1:0] game_active,
  output logic       world_reset,
  output logic       freeze,
  output logic       player_won,
  output logic [9:0] play_seconds
);

  import vga_pkg::*;

  localparam int unsigned FrameW  = cnt_width(FRAMES_PER_SEC);
  localparam int unsigned FreezeW = cnt_width(FREEZE_FRAMES);
  localparam int unsigned InitW   = cnt_width(INIT_CYCLES);

  localparam logic [FrameW-1:0]  FrameLast  = FrameW'(FRAMES_PER_SEC - 1);
  localparam logic [FreezeW-1:0] FreezeLast = FreezeW'(FREEZE_FRAMES - 1);
  localparam logic [InitW-1:0]   InitLast   = InitW'(INIT_CYCLES - 1);
  localparam logic [9:0]         SecMax     = 10'(MAX_SECONDS);

  typedef enum logic [2:0] {
    StMenu,
    StInit,
    StPlay,
    StFreeze,
    StEnd,
    StPause
  } state_e;

  state_e             state_q, state_d;
  logic [InitW-1:0]   init_cnt_q, init_cnt_d;
  logic [FrameW-1:0]  frame_cnt_q, frame_cnt_d;
  logic [FreezeW-1:0] freeze_cnt_q, freeze_cnt_d;
  logic [9:0]         seconds_q, seconds_d;
  logic               won_q, won_d;
  game_active_t       ga_q, ga_d;
  logic               world_reset_q, world_reset_d;
  logic               freeze_q, freeze_d;
  logic               frame_tick;

  frame_tick_gen u_frame_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .vsync (vsync),
    .tick  (frame_tick)
  );

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    seconds_d    = seconds_q;
    won_d        = won_q;

    case (state_q)
      StMenu: begin
        if (game_start && (char_class != 2'd0)) state_d = StInit;
      end
      StInit: begin
        if (init_cnt_q == InitLast) state_d = StPlay;
        else init_cnt_d = init_cnt_q + 1'b1;
      end
      StPlay: begin
        // Loss wins over a simultaneous boss kill; deaths win over pause.
        if (player_dead) begin
          state_d = StFreeze;
          won_d   = 1'b0;
        end else if (boss_dead) begin
          state_d = StFreeze;
          won_d   = 1'b1;
        end
`ifdef PAUSE_EN
        else if (pause_toggle) begin
          state_d = StPause;
        end
`endif
        if (frame_tick) begin
          if (frame_cnt_q == FrameLast) begin
            frame_cnt_d = '0;
            if (seconds_q < SecMax) seconds_d = seconds_q + 10'd1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      StFreeze: begin
        if (frame_tick) begin
          if (freeze_cnt_q == FreezeLast) state_d = StEnd;
          else freeze_cnt_d = freeze_cnt_q + 1'b1;
        end
      end
      StEnd: begin
        if (game_start) state_d = StInit;
      end
`ifdef PAUSE_EN
      StPause: begin
        if (pause_toggle) state_d = StPlay;
      end
`endif
      default: state_d = StMenu;
    endcase

    if ((state_d == StInit) && (state_q != StInit)) begin
      init_cnt_d  = '0;
      frame_cnt_d = '0;
      seconds_d   = '0;
      won_d       = 1'b0;
    end
    if ((state_d == StFreeze) && (state_q != StFreeze)) freeze_cnt_d = '0;

    // Outputs are registered from the next state so they track state_q exactly.
    case (state_d)
      StMenu:  ga_d = GA_MENU;
      StEnd:   ga_d = GA_END;
      default: ga_d = GA_PLAY;
    endcase
    world_reset_d = (state_d == StInit);
    freeze_d      = (state_d == StFreeze) || (state_d == StPause);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StMenu;
      init_cnt_q    <= '0;
      frame_cnt_q   <= '0;
      freeze_cnt_q  <= '0;
      seconds_q     <= '0;
      won_q         <= 1'b0;
      ga_q          <= GA_MENU;
      world_reset_q <= 1'b0;
      freeze_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      freeze_cnt_q  <= freeze_cnt_d;
      seconds_q     <= seconds_d;
      won_q         <= won_d;
      ga_q          <= ga_d;
      world_reset_q <= world_reset_d;
      freeze_q      <= freeze_d;
    end
  end

  assign game_active  = ga_q;
  assign world_reset  = world_reset_q;
  assign freeze       = freeze_q;
  assign player_won   = won_q;
  assign play_seconds = seconds_q;

endmodule
